// File: rtl/stack_initiator.sv
// -----------------------------------------------------------------------------
// stack_initiator
//
// Bus-initiator front end for the ArgonStack responder. Takes one stack
// operation at a time from the CPU control unit, issues it to the responder as
// a one-cycle registered command strobe, waits (bounded) for POP read data and
// returns exactly one response per request. A shadow depth count lets it trap
// overflow and underflow locally without touching the bus.
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Reset        asynchronous, active-low reset
//   i_ReqValid     request strobe, accepted only while o_ReqReady=1
//   o_ReqReady     high only when idle
//   i_ReqOp        00=PUSH, 01=POP, 10=READ_PTR, 11=LOAD_PTR
//   i_ReqData      push data, or new SP in bits [7:0] for LOAD_PTR
//   o_RespValid    one-cycle response strobe
//   o_RespData     popped word, {8'b0,SP} for READ_PTR, 0 otherwise
//   o_RespErr      overflow, underflow or timeout (qualified by o_RespValid)
//   o_Depth        shadow stack depth
//   o_BusCommand   COM_* code driven to the responder
//   o_BusData      data driven to the responder
//   i_BusData      data returned by the responder
//   i_BusValid     responder data valid (only looked at while waiting on POP)
// -----------------------------------------------------------------------------

package stack_pkg;

  typedef enum logic [2:0] {
    COM_NOP      = 3'd0,
    COM_PUSH     = 3'd1,
    COM_POP      = 3'd2,
    COM_READ_PTR = 3'd3,
    COM_LOAD_PTR = 3'd4
  } command_t;

  localparam logic [1:0] OP_PUSH     = 2'b00;
  localparam logic [1:0] OP_POP      = 2'b01;
  localparam logic [1:0] OP_READ_PTR = 2'b10;
  localparam logic [1:0] OP_LOAD_PTR = 2'b11;

endpackage

module stack_initiator #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_ReqValid,
  output logic                      o_ReqReady,
  input  logic [1:0]                i_ReqOp,
  input  logic [DATA_W-1:0]         i_ReqData,
  output logic                      o_RespValid,
  output logic [DATA_W-1:0]         o_RespData,
  output logic                      o_RespErr,
  output logic [$clog2(DEPTH):0]    o_Depth,
  output stack_pkg::command_t       o_BusCommand,
  output logic [DATA_W-1:0]         o_BusData,
  input  logic [DATA_W-1:0]         i_BusData,
  input  logic                      i_BusValid
);

  import stack_pkg::*;

  localparam int DEPTH_W = $clog2(DEPTH) + 1;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);
  // The counter starts at 0 on WAIT entry, so its value TIMEOUT-1 marks the
  // last permitted WAIT cycle.
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  resp_data;
  logic               resp_err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   tmo_cnt;
  command_t           bus_cmd;
  logic [DATA_W-1:0]  bus_data;

  function automatic command_t op_to_cmd(input logic [1:0] op);
    // NOTE: every path assigns the result first, so no storage is implied.
    op_to_cmd = COM_NOP;
    case (op)
      OP_PUSH:     op_to_cmd = COM_PUSH;
      OP_POP:      op_to_cmd = COM_POP;
      OP_READ_PTR: op_to_cmd = COM_READ_PTR;
      OP_LOAD_PTR: op_to_cmd = COM_LOAD_PTR;
      default:     op_to_cmd = COM_NOP;
    endcase
  endfunction

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state     <= S_IDLE;
      op_q      <= OP_PUSH;
      resp_data <= '0;
      resp_err  <= 1'b0;
      depth     <= '0;
      tmo_cnt   <= '0;
      bus_cmd   <= COM_NOP;
      bus_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus_cmd  <= COM_NOP;
          bus_data <= '0;
          if (i_ReqValid) begin
            op_q      <= i_ReqOp;
            resp_data <= '0;
            resp_err  <= 1'b0;
            if ((i_ReqOp == OP_PUSH && depth == DEPTH_FULL) ||
                (i_ReqOp == OP_POP  && depth == '0)) begin
              // Trapped locally: answer at once, never touch the bus.
              resp_err <= 1'b1;
              state    <= S_DONE;
            end else begin
              // The strobe is loaded here so it is a flop output during ISSUE;
              // bus_data doubles as the latched request data.
              bus_cmd  <= op_to_cmd(i_ReqOp);
              bus_data <= i_ReqData;
              state    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          bus_cmd  <= COM_NOP;
          bus_data <= '0;
          case (op_q)
            OP_PUSH: begin
              depth <= depth + DEPTH_W'(1);
              state <= S_DONE;
            end
            OP_LOAD_PTR: begin
              depth <= DEPTH_W'(bus_data[7:0]);
              state <= S_DONE;
            end
            OP_READ_PTR: begin
              // The responder answers a pointer read combinationally.
              resp_data <= i_BusData;
              depth     <= DEPTH_W'(i_BusData[7:0]);
              state     <= S_DONE;
            end
            default: begin
              // POP: the responder moves SP on the strobe, so the decrement
              // stands even if the data never arrives.
              depth   <= depth - DEPTH_W'(1);
              tmo_cnt <= '0;
              state   <= S_WAIT;
            end
          endcase
        end

        S_WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (i_BusValid) begin
            resp_data <= i_BusData;
            resp_err  <= 1'b0;
            state     <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ReqReady   = (state == S_IDLE);
  assign o_RespValid  = (state == S_DONE);
  assign o_RespData   = resp_data;
  assign o_RespErr    = resp_err;
  assign o_Depth      = depth;
  assign o_BusCommand = bus_cmd;
  assign o_BusData    = bus_data;

endmodule
